// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 types, FSM states and bit functions.
// Used by the compression controller and the message-schedule stage.
package sha256_pkg;

  localparam int ROUNDS_DEF = 64;

  typedef logic [31:0] word_t;

  // Eight words, index 0 in the MSBs (a / H0 first).
  typedef logic [0:7][31:0] hvec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADH,
    S_FETCH,
    S_EXEC,
    S_ADD,
    S_FIN
  } state_t;

  function automatic word_t s0(word_t x);
    return {x[1:0], x[31:2]}
         ^ {x[12:0], x[31:13]}
         ^ {x[21:0], x[31:22]};
  endfunction

  function automatic word_t s1(word_t x);
    return {x[5:0], x[31:6]}
         ^ {x[10:0], x[31:11]}
         ^ {x[24:0], x[31:25]};
  endfunction

  function automatic word_t sig0(word_t x);
    return {x[6:0], x[31:7]}
         ^ {x[17:0], x[31:18]}
         ^ {3'b0, x[31:3]};
  endfunction

  function automatic word_t sig1(word_t x);
    return {x[16:0], x[31:17]}
         ^ {x[18:0], x[31:19]}
         ^ {10'b0, x[31:10]};
  endfunction

  function automatic word_t ch(word_t e, word_t f, word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(word_t a, word_t b, word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_compress_ctrl_if.sv
// sha256_compress_ctrl_if: HK constant memory port plus W stream.
// master = compression controller, slave = memory / schedule side.
interface sha256_compress_ctrl_if;
  import sha256_pkg::*;

  logic       HK_RDY;
  logic       HK_SELECTOR;
  logic [2:0] H_ADDR;
  logic [5:0] K_ADDR;
  word_t      HK_DR;
  word_t      W;
  logic       W_VALID;
  logic       W_READY;

  modport master (
    input  HK_RDY, HK_DR, W, W_VALID,
    output HK_SELECTOR, H_ADDR, K_ADDR, W_READY
  );

  modport slave (
    output HK_RDY, HK_DR, W, W_VALID,
    input  HK_SELECTOR, H_ADDR, K_ADDR, W_READY
  );

endinterface

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 round.
// Produces next a..h from current a..h, K[t] and W[t].
module sha256_round
  import sha256_pkg::*;
(
  input  hvec_t v_i,
  input  word_t k_i,
  input  word_t w_i,
  output hvec_t v_o
);

  word_t t1;
  word_t t2;

  // T1/T2 and the working-variable shift
  always_comb begin
    t1 = v_i[7] + s1(v_i[4])
       + ch(v_i[4], v_i[5], v_i[6])
       + k_i + w_i;
    t2 = s0(v_i[0])
       + maj(v_i[0], v_i[1], v_i[2]);
    v_o = {t1 + t2, v_i[0], v_i[1], v_i[2],
           v_i[3] + t1, v_i[4], v_i[5], v_i[6]};
  end

endmodule

// File: rtl/sha256_compress_ctrl.sv
// sha256_compress_ctrl: sequences H load, K fetch and rounds for
// one 512-bit block, then folds the result into DIGEST.
module sha256_compress_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  sha256_compress_ctrl_if.master hk_w,
  input  logic                   START,
  input  logic                   FIRST,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [255:0]           DIGEST
);

  localparam logic [5:0] TLAST = 6'(ROUNDS - 1);

  state_t     state_q, state_d;
  logic [5:0] t_q, t_d;
  logic [3:0] hc_q, hc_d;
  hvec_t      v_q, v_d;
  hvec_t      hv_q, hv_d;
  word_t      k_q, k_d;
  logic       kf_q, kf_d;
  word_t      k_use;
  hvec_t      v_nx;
  logic [2:0] hidx;

  // K arrives on the first EXEC cycle; later cycles use the latch
  assign k_use  = kf_q ? hk_w.HK_DR : k_q;
  assign DIGEST = hv_q;
  assign hidx   = hc_q[2:0] - 3'd1;

  sha256_round u_round (
    .v_i (v_q),
    .k_i (k_use),
    .w_i (hk_w.W),
    .v_o (v_nx)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // datapath and counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      t_q  <= '0;
      hc_q <= '0;
      v_q  <= '0;
      hv_q <= '0;
      k_q  <= '0;
      kf_q <= 1'b0;
    end else begin
      t_q  <= t_d;
      hc_q <= hc_d;
      v_q  <= v_d;
      hv_q <= hv_d;
      k_q  <= k_d;
      kf_q <= kf_d;
    end
  end

  // next state, datapath updates and outputs
  always_comb begin
    state_d          = state_q;
    t_d              = t_q;
    hc_d             = hc_q;
    v_d              = v_q;
    hv_d             = hv_q;
    k_d              = k_q;
    kf_d             = 1'b0;
    BUSY             = 1'b0;
    DONE             = 1'b0;
    hk_w.HK_SELECTOR = 1'b0;
    hk_w.H_ADDR      = '0;
    hk_w.K_ADDR      = t_q;
    hk_w.W_READY     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START && hk_w.HK_RDY) begin
          t_d  = '0;
          hc_d = '0;
          if (FIRST) begin
            state_d = S_LOADH;
          end else begin
            state_d = S_FETCH;
            v_d     = hv_q;
          end
        end
      end
      S_LOADH: begin
        BUSY        = 1'b1;
        hk_w.H_ADDR = hc_q[2:0];
        if (hc_q != 4'd0) begin
          hv_d[hidx] = hk_w.HK_DR;
          v_d[hidx]  = hk_w.HK_DR;
        end
        if (hc_q == 4'd8) state_d = S_FETCH;
        else              hc_d    = hc_q + 4'd1;
      end
      S_FETCH: begin
        BUSY             = 1'b1;
        hk_w.HK_SELECTOR = 1'b1;
        kf_d             = 1'b1;
        state_d          = S_EXEC;
      end
      S_EXEC: begin
        BUSY             = 1'b1;
        hk_w.HK_SELECTOR = 1'b1;
        hk_w.W_READY     = 1'b1;
        if (kf_q) k_d = hk_w.HK_DR;
        if (hk_w.W_VALID) begin
          v_d = v_nx;
          if (t_q == TLAST) begin
            state_d = S_ADD;
          end else begin
            t_d     = t_q + 6'd1;
            state_d = S_FETCH;
          end
        end
      end
      S_ADD: begin
        BUSY = 1'b1;
        for (int i = 0; i < 8; i++) begin
          hv_d[i] = hv_q[i] + v_q[i];
        end
        state_d = S_FIN;
      end
      S_FIN: begin
        DONE    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// tb_sha256_compress_ctrl: HK ROM model, W stream driver and a
// plain SHA-256 reference model for the compression controller.
module tb_sha256_compress_ctrl;

  localparam int ROUNDS = 64;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] ABC_DG = {
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] TWO_DG = {
    32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
  localparam logic [511:0] ABC_BLK = {
    32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] TWO_B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         RST;
  logic         START;
  logic         FIRST;
  logic         BUSY;
  logic         DONE;
  logic [255:0] DIGEST;

  int           checks = 0;
  int           errors = 0;
  logic [255:0] exp_chain;
  logic [31:0]  wexp [64];

  sha256_compress_ctrl_if bus ();

  sha256_compress_ctrl #(.ROUNDS(ROUNDS)) dut (
    .CLK    (clk),
    .RST    (RST),
    .hk_w   (bus),
    .START  (START),
    .FIRST  (FIRST),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .DIGEST (DIGEST)
  );

  always #5 clk = ~clk;

  // HK memory: registered read, one cycle after address
  always @(posedge clk) begin
    if (bus.HK_SELECTOR) bus.HK_DR <= KT[bus.K_ADDR];
    else bus.HK_DR <= IV[255 - 32 * bus.H_ADDR -: 32];
  end

  function automatic logic [31:0] rotr(input logic [31:0] x,
                                       input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sched(input logic [31:0] w2,
      input logic [31:0] w7, input logic [31:0] w15,
      input logic [31:0] w16);
    return (rotr(w2, 17) ^ rotr(w2, 19) ^ (w2 >> 10)) + w7
         + (rotr(w15, 7) ^ rotr(w15, 18) ^ (w15 >> 3)) + w16;
  endfunction

  task automatic fill_w(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) wexp[i] = blk[511 - 32 * i -: 32];
    for (int i = 16; i < 64; i++)
      wexp[i] = sched(wexp[i-2], wexp[i-7], wexp[i-15], wexp[i-16]);
  endtask

  function automatic logic [255:0] ref_compress(
      input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32 * i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = sched(w[i-2], w[i-7], w[i-15], w[i-16]);
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32 * i -: 32];
    for (int t = 0; t < ROUNDS; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++)
      r[255 - 32 * i -: 32] = hin[255 - 32 * i -: 32] + v[i];
    return r;
  endfunction

  // mode 0: plain, 1: extra START at round 10, 2: RST at round 30
  task automatic run_block(input logic [511:0] blk, input bit first,
      input int gapmax, input int mode, output int lat,
      output int fires, output bit seen, output logic [255:0] dg);
    int gap;
    bit inj;
    bit bad;
    fill_w(blk);
    @(negedge clk);
    START = 1'b1;
    FIRST = first;
    bus.W_VALID = 1'b0;
    lat = 0; fires = 0; seen = 1'b0; gap = 0; inj = 1'b0;
    dg = 'x;
    while (!seen && lat < 4000) begin
      @(negedge clk);
      lat++;
      START = 1'b0;
      if (DONE === 1'b1) begin
        seen = 1'b1;
        dg = DIGEST;
        bus.W_VALID = 1'b0;
      end else begin
        if (mode == 1 && fires == 10 && !inj) begin
          START = 1'b1;
          FIRST = 1'b1;
          inj = 1'b1;
        end
        if (mode == 2 && fires == 30) begin
          RST = 1'b1;
          bus.W_VALID = 1'b0;
          @(negedge clk);
          RST = 1'b0;
          checks++;
          if (BUSY !== 1'b0 || DONE !== 1'b0 || DIGEST !== '0 ||
              bus.W_READY !== 1'b0 || bus.K_ADDR !== 6'd0) begin
            errors++;
            $display("FAIL midreset_state: busy=%b done=%b ready=%b kaddr=%0d digest=%h expected all zero",
                     BUSY, DONE, bus.W_READY, bus.K_ADDR, DIGEST);
          end
          bad = 1'b0;
          repeat (150) begin
            @(negedge clk);
            if (DONE !== 1'b0 || BUSY !== 1'b0) bad = 1'b1;
          end
          checks++;
          if (bad) begin
            errors++;
            $display("FAIL midreset_nodone: got DONE/BUSY activity expected none");
          end
          return;
        end
        checks++;
        if (BUSY === 1'b0 && bus.W_READY !== 1'b0) begin
          errors++;
          $display("FAIL ready_idle: got W_READY=%b expected 0", bus.W_READY);
        end
        checks++;
        if (bus.K_ADDR > 6'(ROUNDS - 1)) begin
          errors++;
          $display("FAIL k_addr_range: got %0d expected <= %0d",
                   bus.K_ADDR, ROUNDS - 1);
        end
        if (gap > 0) begin
          bus.W_VALID = 1'b0;
          gap--;
        end else begin
          bus.W_VALID = (fires < 64);
          bus.W = wexp[fires < 64 ? fires : 63];
        end
        if (bus.W_VALID && bus.W_READY) begin
          fires++;
          gap = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no DONE after %0d cycles expected DONE", lat);
    end else begin
      @(negedge clk);
      checks++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || DIGEST !== dg) begin
        errors++;
        $display("FAIL after_done: done=%b busy=%b digest=%h expected 0 0 %h",
                 DONE, BUSY, DIGEST, dg);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; FIRST = 1'b0;
    bus.HK_RDY = 1'b1; bus.W_VALID = 1'b0; bus.W = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b expected 0 0", BUSY, DONE);
    end
    checks++;
    if (DIGEST !== '0) begin
      errors++;
      $display("FAIL reset_digest: got %h expected 0", DIGEST);
    end
    checks++;
    if (bus.W_READY !== 1'b0 || bus.HK_SELECTOR !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: ready=%b sel=%b expected 0 0",
               bus.W_READY, bus.HK_SELECTOR);
    end
    checks++;
    if (bus.H_ADDR !== 3'd0 || bus.K_ADDR !== 6'd0) begin
      errors++;
      $display("FAIL reset_addr: h=%0d k=%0d expected 0 0",
               bus.H_ADDR, bus.K_ADDR);
    end
    RST = 1'b0;
    exp_chain = '0;
  endtask

  task automatic test_abc();
    int lat, fires; bit seen; logic [255:0] dg, e;
    run_block(ABC_BLK, 1'b1, 0, 0, lat, fires, seen, dg);
    e = ref_compress(IV, ABC_BLK);
    checks++;
    if (lat !== 139) begin
      errors++;
      $display("FAIL abc_latency: got %0d expected 139", lat);
    end
    checks++;
    if (fires !== 64) begin
      errors++;
      $display("FAIL abc_words: got %0d expected 64", fires);
    end
    checks++;
    if (dg !== ABC_DG) begin
      errors++;
      $display("FAIL abc_digest: got %h expected %h", dg, ABC_DG);
    end
    checks++;
    if (dg !== e) begin
      errors++;
      $display("FAIL abc_model: got %h expected %h", dg, e);
    end
    exp_chain = e;
  endtask

  task automatic test_two_block();
    int lat, fires; bit seen; logic [255:0] dg, e;
    run_block(TWO_B1, 1'b1, 0, 0, lat, fires, seen, dg);
    e = ref_compress(IV, TWO_B1);
    checks++;
    if (dg !== e) begin
      errors++;
      $display("FAIL two_b1: got %h expected %h", dg, e);
    end
    run_block(TWO_B2, 1'b0, 0, 0, lat, fires, seen, dg);
    checks++;
    if (lat !== 130) begin
      errors++;
      $display("FAIL two_latency: got %0d expected 130", lat);
    end
    checks++;
    if (dg !== TWO_DG) begin
      errors++;
      $display("FAIL two_digest: got %h expected %h", dg, TWO_DG);
    end
    exp_chain = ref_compress(e, TWO_B2);
  endtask

  task automatic test_throttle();
    int lat, fires; bit seen; logic [255:0] dg;
    run_block(ABC_BLK, 1'b1, 5, 0, lat, fires, seen, dg);
    checks++;
    if (dg !== ABC_DG || fires !== 64) begin
      errors++;
      $display("FAIL throttle_digest: got %h words %0d expected %h words 64",
               dg, fires, ABC_DG);
    end
    checks++;
    if (lat < 139) begin
      errors++;
      $display("FAIL throttle_latency: got %0d expected >= 139", lat);
    end
    exp_chain = ABC_DG;
  endtask

  task automatic test_start_gating();
    int lat, fires; bit seen, bad; logic [255:0] dg;
    bus.HK_RDY = 1'b0;
    @(negedge clk);
    START = 1'b1; FIRST = 1'b1;
    @(negedge clk);
    START = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      if (BUSY !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL gate_hkrdy: got BUSY=1 expected 0");
    end
    bus.HK_RDY = 1'b1;
    run_block(ABC_BLK, 1'b1, 0, 1, lat, fires, seen, dg);
    checks++;
    if (dg !== ABC_DG || lat !== 139) begin
      errors++;
      $display("FAIL gate_busy: got %h lat %0d expected %h lat 139",
               dg, lat, ABC_DG);
    end
    exp_chain = ABC_DG;
  endtask

  task automatic test_reset_mid();
    int lat, fires; bit seen; logic [255:0] dg;
    run_block(ABC_BLK, 1'b1, 0, 2, lat, fires, seen, dg);
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midreset_done: got DONE expected none");
    end
    exp_chain = '0;
    run_block(ABC_BLK, 1'b1, 0, 0, lat, fires, seen, dg);
    checks++;
    if (dg !== ABC_DG) begin
      errors++;
      $display("FAIL midreset_restart: got %h expected %h", dg, ABC_DG);
    end
    exp_chain = ABC_DG;
  endtask

  task automatic test_random();
    int lat, fires, gm; bit seen, first; logic [255:0] dg, e;
    logic [511:0] blk;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 16; i++) blk[511 - 32 * i -: 32] = $urandom;
      first = (n == 0) ? 1'b0 : 1'($urandom_range(1, 0));
      gm = int'($urandom_range(3, 0));
      run_block(blk, first, gm, 0, lat, fires, seen, dg);
      e = first ? ref_compress(IV, blk) : ref_compress(exp_chain, blk);
      checks++;
      if (dg !== e) begin
        errors++;
        $display("FAIL random_digest[%0d]: got %h expected %h", n, dg, e);
      end
      checks++;
      if (gm == 0 && lat !== (first ? 139 : 130)) begin
        errors++;
        $display("FAIL random_latency[%0d]: got %0d expected %0d",
                 n, lat, first ? 139 : 130);
      end
      exp_chain = e;
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_two_block();
    test_throttle();
    test_start_gating();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
